// File: rtl/rv32_pkg.sv
// rv32_pkg: shared opcodes, sequencer states and instruction classes for the multicycle RV32I core.
package rv32_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR} seq_state_t;
    typedef enum logic [2:0] {ALU, BRANCH, JUMP, LOAD, STORE, SYSTEM, ILLEGAL} instr_class_t;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps the IR opcode field to an instruction class and a register-write flag.
module opcode_classifier
    import rv32_pkg::*;
(
    input  logic [6:0]   ir_opcode,
    output instr_class_t cls,
    output logic         writes_rd
);
    always_comb begin
        case (ir_opcode)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: cls = ALU;
            OP_JAL, OP_JALR:                  cls = JUMP;
            OP_BRANCH:                        cls = BRANCH;
            OP_LOAD:                          cls = LOAD;
            OP_STORE:                         cls = STORE;
            OP_SYSTEM:                        cls = SYSTEM;
            default:                          cls = ILLEGAL;
        endcase
    end

    assign writes_rd = cls inside {ALU, JUMP, LOAD};
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM sequencing memory, IR, register file and PC for a multicycle
// RV32I core, with wait-state handshake, cycle/instret counters and sticky halt/illegal/timeout flags.
module multicycle_sequencer
    import rv32_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       ir_opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_is_data,
    output logic             mem_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    localparam int WW = $clog2(TIMEOUT + 2);

    seq_state_t   st;
    instr_class_t cls;
    logic         writes_rd;
    logic         waiting;
    logic         expired;
    logic [WW-1:0] wait_cnt;

    opcode_classifier u_cls (
        .ir_opcode (ir_opcode),
        .cls       (cls),
        .writes_rd (writes_rd)
    );

    assign state   = st;
    assign waiting = (st == FETCH || st == MEM) && !mem_ready;
    // A ready on the limit cycle completes normally because waiting is already low then.
    assign expired = TIMEOUT != 0 && waiting && wait_cnt == WW'(TIMEOUT - 1);

    assign mem_req     = !rst && (st == FETCH || st == MEM);
    assign mem_is_data = !rst && st == MEM;
    assign mem_we      = !rst && st == MEM && cls == STORE && mem_ready;
    assign ir_we       = !rst && st == FETCH && mem_ready;
    assign reg_we      = !rst && st == WB && writes_rd;
    assign pc_we       = !rst && (st == WB || (st == DECODE && cls == SYSTEM));

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
            if (st != HALT && st != ERROR) cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_we) instret_cnt <= instret_cnt + 1'b1;
            if (expired) timeout <= 1'b1;
            if (st == DECODE && cls == ILLEGAL) illegal <= 1'b1;
            if (st == DECODE && cls == SYSTEM) halted <= 1'b1;
            case (st)
                IDLE:    st <= FETCH;
                FETCH:   st <= mem_ready ? DECODE : expired ? ERROR : FETCH;
                DECODE:  st <= cls == ILLEGAL ? ERROR : cls == SYSTEM ? HALT : EXEC;
                EXEC:    st <= (cls == LOAD || cls == STORE) ? MEM : WB;
                MEM:     st <= mem_ready ? WB : expired ? ERROR : MEM;
                WB:      st <= FETCH;
                default: st <= st;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed table of per-cycle vectors plus hand sequences for error,
// halt, timeout, reset-during-wait and counter wrap.
module tb_multicycle_sequencer;
    import rv32_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rdy = 1'b0;
    logic [6:0]  op = '0;
    logic        mem_req, mem_is_data, mem_we, ir_we, reg_we, pc_we, halted, illegal, timeout;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        rst_s = 1'b1, rdy_s = 1'b0;
    logic [6:0]  op_s = '0;
    logic        mem_req_s, mem_is_data_s, mem_we_s, ir_we_s, reg_we_s, pc_we_s;
    logic        halted_s, illegal_s, timeout_s;
    logic [2:0]  state_s;
    logic [3:0]  cycle_s, instret_s;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .ir_opcode(op), .mem_ready(rdy),
        .mem_req(mem_req), .mem_is_data(mem_is_data), .mem_we(mem_we), .ir_we(ir_we),
        .reg_we(reg_we), .pc_we(pc_we), .state(state), .halted(halted), .illegal(illegal),
        .timeout(timeout), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    multicycle_sequencer #(.CNT_W(4), .TIMEOUT(4)) dut_s (
        .clk(clk), .rst(rst_s), .ir_opcode(op_s), .mem_ready(rdy_s),
        .mem_req(mem_req_s), .mem_is_data(mem_is_data_s), .mem_we(mem_we_s), .ir_we(ir_we_s),
        .reg_we(reg_we_s), .pc_we(pc_we_s), .state(state_s), .halted(halted_s),
        .illegal(illegal_s), .timeout(timeout_s), .cycle_cnt(cycle_s), .instret_cnt(instret_s)
    );

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic [2:0] st;
        logic [5:0] strb;
        int         ir;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic row(input logic [6:0] o, input logic r, input logic [2:0] s,
                       input logic [5:0] b, input int n);
        tbl.push_back('{op: o, rdy: r, st: s, strb: b, ir: n});
    endtask

    task automatic reset_main();
        rst = 1'b1;
        #1;
        chk("rst_strobes", {26'd0, mem_req, mem_is_data, mem_we, ir_we, reg_we, pc_we}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_state", state, IDLE);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_instret", instret_cnt, 0);
        chk("rst_flags", {halted, illegal, timeout}, 0);
    endtask

    task automatic reset_small();
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        #1;
        chk("rst_s_state", state_s, IDLE);
        chk("rst_s_flags", {halted_s, illegal_s, timeout_s}, 0);
    endtask

    initial begin
        // strobe vector: {mem_req, mem_is_data, mem_we, ir_we, reg_we, pc_we}
        row(OP_IMM,    1, IDLE,   6'b000000, 0);
        row(OP_IMM,    1, FETCH,  6'b100100, 0);
        row(OP_IMM,    1, DECODE, 6'b000000, 0);
        row(OP_IMM,    1, EXEC,   6'b000000, 0);
        row(OP_IMM,    1, WB,     6'b000011, 0);
        row(OP_LOAD,   1, FETCH,  6'b100100, 1);
        row(OP_LOAD,   1, DECODE, 6'b000000, 1);
        row(OP_LOAD,   1, EXEC,   6'b000000, 1);
        row(OP_LOAD,   0, MEM,    6'b110000, 1);
        row(OP_LOAD,   0, MEM,    6'b110000, 1);
        row(OP_LOAD,   0, MEM,    6'b110000, 1);
        row(OP_LOAD,   1, MEM,    6'b110000, 1);
        row(OP_LOAD,   1, WB,     6'b000011, 1);
        row(OP_STORE,  1, FETCH,  6'b100100, 2);
        row(OP_STORE,  1, DECODE, 6'b000000, 2);
        row(OP_STORE,  1, EXEC,   6'b000000, 2);
        row(OP_STORE,  1, MEM,    6'b111000, 2);
        row(OP_STORE,  1, WB,     6'b000001, 2);
        row(OP_BRANCH, 1, FETCH,  6'b100100, 3);
        row(OP_BRANCH, 1, DECODE, 6'b000000, 3);
        row(OP_BRANCH, 1, EXEC,   6'b000000, 3);
        row(OP_BRANCH, 1, WB,     6'b000001, 3);
        row(OP_BRANCH, 0, FETCH,  6'b100000, 4);

        reset_main();
        foreach (tbl[i]) begin
            op  = tbl[i].op;
            rdy = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_state", i), state, tbl[i].st);
            chk($sformatf("row%0d_strobes", i),
                {mem_req, mem_is_data, mem_we, ir_we, reg_we, pc_we}, tbl[i].strb);
            chk($sformatf("row%0d_instret", i), instret_cnt, tbl[i].ir);
            chk($sformatf("row%0d_cycle", i), cycle_cnt, i);
            @(negedge clk);
        end
        #1;
        chk("tbl_end_instret", instret_cnt, 4);
        chk("tbl_end_cycle", cycle_cnt, 23);

        // illegal opcode: absorbing ERROR with a frozen cycle counter
        reset_main();
        op = 7'b0000000;
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("ill_decode_state", state, DECODE);
        chk("ill_decode_pc_we", pc_we, 0);
        @(negedge clk);
        #1;
        chk("ill_state", state, ERROR);
        chk("ill_flag", illegal, 1);
        chk("ill_cycle", cycle_cnt, 3);
        repeat (10) @(negedge clk);
        #1;
        chk("ill_cycle_frozen", cycle_cnt, 3);
        chk("ill_state_held", state, ERROR);
        chk("ill_strobes", {mem_req, mem_is_data, mem_we, ir_we, reg_we, pc_we}, 0);
        chk("ill_instret", instret_cnt, 0);
        reset_main();

        // ECALL retires and halts
        op = OP_SYSTEM;
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("ecall_decode_pc_we", pc_we, 1);
        chk("ecall_decode_reg_we", reg_we, 0);
        @(negedge clk);
        #1;
        chk("ecall_state", state, HALT);
        chk("ecall_halted", halted, 1);
        chk("ecall_instret", instret_cnt, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("halt_cycle_frozen", cycle_cnt, 3);
        chk("halt_strobes", {mem_req, mem_is_data, mem_we, ir_we, reg_we, pc_we}, 0);

        // reset during a MEM wait
        reset_main();
        op = OP_LOAD;
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_mem_state", state, MEM);
        chk("midrst_mem_req", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b1;
        #1;
        chk("midrst_strobes", {mem_req, mem_is_data, mem_we, ir_we, reg_we, pc_we}, 0);
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b0;
        #1;
        chk("midrst_state", state, IDLE);
        chk("midrst_req", mem_req, 0);
        chk("midrst_cycle", cycle_cnt, 0);
        chk("midrst_instret", instret_cnt, 0);

        // timeout: four unanswered fetch cycles
        op_s = OP_IMM;
        rdy_s = 1'b0;
        reset_small();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("to_wait%0d_state", k), state_s, FETCH);
            @(negedge clk);
        end
        #1;
        chk("to_state", state_s, ERROR);
        chk("to_flag", timeout_s, 1);
        chk("to_strobes", {mem_req_s, mem_is_data_s, mem_we_s, ir_we_s, reg_we_s, pc_we_s}, 0);

        // ready on the limit cycle completes the fetch
        reset_small();
        @(negedge clk);
        repeat (3) @(negedge clk);
        rdy_s = 1'b1;
        #1;
        chk("limit_ir_we", ir_we_s, 1);
        @(negedge clk);
        #1;
        chk("limit_state", state_s, DECODE);
        chk("limit_timeout", timeout_s, 0);

        // 4-bit counters wrap after 16 instructions
        reset_small();
        repeat (61) @(negedge clk);
        #1;
        chk("wrap_pre_instret", instret_s, 15);
        chk("wrap_pre_state", state_s, FETCH);
        repeat (4) @(negedge clk);
        #1;
        chk("wrap_instret", instret_s, 0);
        chk("wrap_cycle", cycle_s, 1);
        chk("wrap_state", state_s, FETCH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
